// File: rtl/main_memory.sv
// rtl/main_memory.sv - line-oriented main memory model with fixed access latency; optional per-word write mask under MAIN_MEMORY_WMASK_EN
module main_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [31:0]                   req_addr,
    input  logic [BLOCK_WORDS*DATA_W-1:0] req_wdata,
`ifdef MAIN_MEMORY_WMASK_EN
    input  logic [BLOCK_WORDS-1:0]        req_wmask,
`endif
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [BLOCK_WORDS*DATA_W-1:0] resp_rdata,
    output logic                          resp_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [CNT_W-1:0]                count;
    logic                            accept;
    logic                            commit;

    logic                            op_we;
    logic                            op_err;
    logic [ADDR_W-1:0]               op_base;
    logic [BLOCK_WORDS*DATA_W-1:0]   op_wdata;
    logic [BLOCK_WORDS-1:0]          op_wmask;

    logic [DATA_W-1:0]               mem [DEPTH];

    // Next-state and handshake decode; commit marks the single edge where the array is touched
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, latency countdown and response registers (held stable through RESP)
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            op_we      <= 1'b0;
            op_err     <= 1'b0;
            op_base    <= '0;
            op_wdata   <= '0;
            op_wmask   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                count    <= CNT_W'(LATENCY - 1);
                op_we    <= req_we;
                op_err   <= |req_addr[31:ADDR_W];
                op_base  <= req_addr[ADDR_W-1:0] & ~ADDR_W'(BLOCK_WORDS - 1);
                op_wdata <= req_wdata;
`ifdef MAIN_MEMORY_WMASK_EN
                op_wmask <= req_wmask;
`else
                op_wmask <= '1;
`endif
            end else if (state == BUSY && count != '0) begin
                count <= count - 1'b1;
            end
            if (commit) begin
                resp_err <= op_err;
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    resp_rdata[i*DATA_W +: DATA_W] <= (op_we || op_err) ? '0
                                                      : mem[op_base + ADDR_W'(i)];
                end
            end
        end
    end

    // Array write at commit; no reset so contents survive reset, and a reset edge blocks a pending write
    always_ff @(posedge clock) begin
        if (commit && !reset && op_we && !op_err) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (op_wmask[i]) begin
                    mem[op_base + ADDR_W'(i)] <= op_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, bits per word.
REQ-002 The block SHALL provide parameter ADDR_W, default 12, word-address bits implemented (depth = 2**ADDR_W words).
REQ-003 The block SHALL provide parameter BLOCK_WORDS, default 4, words per line transfer (power of two, >=1).
REQ-004 The block SHALL provide parameter LATENCY, default 4, cycles from request acceptance to response (>=1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have these ports:
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  req_valid  in  1  request present
  req_ready  out  1  block can accept a request
  req_we  in  1  1 = line write, 0 = line read
  req_addr  in  32  word address; low log2(BLOCK_WORDS) bits ignored
  req_wdata  in  BLOCK_WORDS*DATA_W  write line; lane i = bits [i*DATA_W +: DATA_W] = word base+i
  req_wmask  in  BLOCK_WORDS  per-word write enable (present only with MAIN_MEMORY_WMASK_EN)
  resp_valid  out  1  response present
  resp_ready  in  1  consumer accepts response
  resp_rdata  out  BLOCK_WORDS*DATA_W  read line, same lane order
  resp_err  out  1  address out of range

Function
REQ-007 States SHALL be IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-008 A request SHALL be accepted at a rising edge where req_valid & req_ready; req_we, aligned base address, req_wdata (and mask) are captured there; IDLE->BUSY, down-counter loaded with LATENCY-1.
REQ-009 In BUSY the counter SHALL decrement each cycle; at the edge where it is 0, BUSY->RESP and the array access is performed.
REQ-010 resp_valid SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-011 On a read, resp_rdata SHALL hold the BLOCK_WORDS words at base..base+BLOCK_WORDS-1 as sampled at the BUSY->RESP edge.
REQ-012 On a write, the array SHALL be updated at the BUSY->RESP edge; resp_rdata SHALL be 0.
REQ-013 An address with any nonzero bit in req_addr[31:ADDR_W] SHALL produce resp_err = 1, no array write, resp_rdata = 0.
REQ-014 resp_valid, resp_rdata, resp_err SHALL stay stable while resp_valid & !resp_ready.
REQ-015 At an edge with resp_valid & resp_ready the block SHALL go RESP->IDLE; resp_valid drops the next cycle.
REQ-016 Minimum spacing between accepting edges SHALL be LATENCY+2 cycles; no request overlap or reordering.
REQ-017 Inputs req_* SHALL be ignored outside IDLE; resp_ready SHALL be ignored outside RESP.

Reset
REQ-018 With reset high at a rising edge: state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, counter = 0.
REQ-019 Reset during BUSY SHALL discard the pending request; an uncommitted write SHALL NOT reach the array.
REQ-020 Reset SHALL NOT alter array contents.

Configuration
REQ-021 With MAIN_MEMORY_WMASK_EN defined, port req_wmask SHALL exist and a write SHALL update only lanes whose mask bit is 1.
REQ-022 Without MAIN_MEMORY_WMASK_EN, port req_wmask SHALL be absent and a write SHALL update all BLOCK_WORDS lanes.

Verification (defaults: DATA_W=32, ADDR_W=12, BLOCK_WORDS=4, LATENCY=4)
REQ-023 Write req_addr=0x10, lanes 0..3 = 0x11,0x22,0x33,0x44, resp_ready=1 -> resp_valid exactly 4 cycles after acceptance, resp_err=0; then read req_addr=0x13 -> resp_rdata lanes 0..3 = 0x11,0x22,0x33,0x44.
REQ-024 Read with resp_ready held 0 for 3 cycles after resp_valid -> resp_valid/resp_rdata constant, req_ready=0; resp_ready=1 -> req_ready=1 one cycle after handshake.
REQ-025 Write req_addr=0x1000 data 0xDEAD in all lanes -> resp_err=1, resp_rdata=0; read 0x000 -> prior contents unchanged.
REQ-026 Reset asserted 2 cycles after accepting a write of 0xAAAA at 0x20 -> resp_valid never rises, req_ready=1 after reset; read 0x20 -> old data.
REQ-027 req_valid held 1, resp_ready held 1, three reads -> accepting edges spaced exactly 6 cycles.
REQ-028 With MAIN_MEMORY_WMASK_EN, write 0x10 all lanes 0xFF, mask 4'b0101, over line 0x11..0x44 -> read gives 0xFF,0x22,0xFF,0x44.
